// File: rtl/uart_io_master_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_io_master_if
// Description : UART byte-stream and 16-bit io bus signals of the debug master.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_io_master_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_rd;
  logic        tx_busy;
  logic        tx_wr;
  logic [7:0]  tx_data;
  logic        bus_req;
  logic        bus_gnt;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_addr;
  logic [15:0] io_dout;
  logic [15:0] io_din;

  modport master (
    input  rx_valid, rx_data, tx_busy, bus_gnt, io_din,
    output rx_rd, tx_wr, tx_data, bus_req, io_rd, io_wr, io_addr, io_dout
  );

  modport slave (
    output rx_valid, rx_data, tx_busy, bus_gnt, io_din,
    input  rx_rd, tx_wr, tx_data, bus_req, io_rd, io_wr, io_addr, io_dout
  );
endinterface
`default_nettype wire

// File: rtl/uart_io_master.sv
`default_nettype none
// ============================================================================
// Module      : uart_io_master
// Description : UART-driven debug initiator issuing single io bus reads/writes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_io_master #(
  parameter int         TIMEOUT  = 1200000,
  parameter logic [7:0] ACK_BYTE = 8'h06,
  parameter logic [7:0] NAK_BYTE = 8'h15
) (
  input  logic               clk,
  input  logic               resetq,
  uart_io_master_if.master   io
);

  localparam int              c_TW       = $clog2(TIMEOUT + 1);
  localparam logic [c_TW-1:0] c_TMO_MAX  = c_TW'(TIMEOUT);
  localparam logic [7:0]      c_CMD_WR   = 8'h57;
  localparam logic [7:0]      c_CMD_RD   = 8'h52;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARG  = 3'd1,
    S_REQ  = 3'd2,
    S_ACC  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t          r_state;
  logic            r_rx_rd;
  logic            r_rx_gap;
  logic            r_tx_wr;
  logic            r_tx_gap;
  logic [7:0]      r_tx_data;
  logic            r_bus_req;
  logic            r_io_rd;
  logic            r_io_wr;
  logic [15:0]     r_io_addr;
  logic [15:0]     r_io_dout;
  logic            r_is_wr;
  logic [2:0]      r_arg_cnt;
  logic [31:0]     r_shift;
  logic [15:0]     r_resp_buf;
  logic [1:0]      r_resp_cnt;
  logic [c_TW-1:0] r_tmo;

  assign io.rx_rd   = r_rx_rd;
  assign io.tx_wr   = r_tx_wr;
  assign io.tx_data = r_tx_data;
  assign io.bus_req = r_bus_req;
  assign io.io_rd   = r_io_rd;
  assign io.io_wr   = r_io_wr;
  assign io.io_addr = r_io_addr;
  assign io.io_dout = r_io_dout;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_state    <= S_IDLE;
      r_rx_rd    <= 1'b0;
      r_rx_gap   <= 1'b0;
      r_tx_wr    <= 1'b0;
      r_tx_gap   <= 1'b0;
      r_tx_data  <= 8'h00;
      r_bus_req  <= 1'b0;
      r_io_rd    <= 1'b0;
      r_io_wr    <= 1'b0;
      r_io_addr  <= 16'h0000;
      r_io_dout  <= 16'h0000;
      r_is_wr    <= 1'b0;
      r_arg_cnt  <= 3'd0;
      r_shift    <= 32'h0;
      r_resp_buf <= 16'h0000;
      r_resp_cnt <= 2'd0;
      r_tmo      <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_ARG: begin
          // Byte is taken on the edge that ends the rx_rd pulse; the following
          // cycle is a gap so the UART's valid flag can settle.
          if (r_rx_rd) begin
            r_rx_rd  <= 1'b0;
            r_rx_gap <= 1'b1;
            r_tmo    <= '0;
            if (r_state == S_IDLE) begin
              case (io.rx_data)
                c_CMD_WR: begin
                  r_state   <= S_ARG;
                  r_is_wr   <= 1'b1;
                  r_arg_cnt <= 3'd4;
                end
                c_CMD_RD: begin
                  r_state   <= S_ARG;
                  r_is_wr   <= 1'b0;
                  r_arg_cnt <= 3'd2;
                end
                default: begin
                  r_state    <= S_RESP;
                  r_resp_buf <= {NAK_BYTE, 8'h00};
                  r_resp_cnt <= 2'd1;
                  r_tx_gap   <= 1'b0;
                end
              endcase
            end else begin
              r_shift   <= {r_shift[23:0], io.rx_data};
              r_arg_cnt <= r_arg_cnt - 3'd1;
              if (r_arg_cnt == 3'd1) begin
                r_state   <= S_REQ;
                r_bus_req <= 1'b1;
              end
            end
          end else begin
            if (r_rx_gap) begin
              r_rx_gap <= 1'b0;
            end else if (io.rx_valid) begin
              r_rx_rd <= 1'b1;
            end
            if (r_state == S_ARG) begin
              if (r_tmo == c_TMO_MAX) begin
                r_state <= S_IDLE;
                r_tmo   <= '0;
              end else begin
                r_tmo <= r_tmo + 1'b1;
              end
            end
          end
        end

        S_REQ: begin
          if (io.bus_gnt) begin
            r_state <= S_ACC;
            if (r_is_wr) begin
              r_io_addr <= r_shift[31:16];
              r_io_dout <= r_shift[15:0];
              r_io_wr   <= 1'b1;
            end else begin
              r_io_addr <= r_shift[15:0];
              r_io_rd   <= 1'b1;
            end
          end
        end

        S_ACC: begin
          r_io_wr    <= 1'b0;
          r_io_rd    <= 1'b0;
          r_bus_req  <= 1'b0;
          r_state    <= S_RESP;
          r_tx_gap   <= 1'b0;
          if (r_is_wr) begin
            r_resp_buf <= {ACK_BYTE, 8'h00};
            r_resp_cnt <= 2'd1;
          end else begin
            r_resp_buf <= io.io_din;
            r_resp_cnt <= 2'd2;
          end
        end

        S_RESP: begin
          // tx_busy is not trusted on the cycle after a pulse; the UART
          // raises it one clock late.
          if (r_tx_wr) begin
            r_tx_wr    <= 1'b0;
            r_tx_gap   <= 1'b1;
            r_resp_buf <= {r_resp_buf[7:0], 8'h00};
            r_resp_cnt <= r_resp_cnt - 2'd1;
            if (r_resp_cnt == 2'd1) begin
              r_state <= S_IDLE;
            end
          end else if (r_tx_gap) begin
            r_tx_gap <= 1'b0;
          end else if (!io.tx_busy) begin
            r_tx_wr   <= 1'b1;
            r_tx_data <= r_resp_buf[15:8];
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
